// File: rtl/car_pkg.sv
// Shared types and constants for the board reset sequencer.
package car_pkg;

  typedef enum logic [2:0] {
    S_HOLD,
    S_REL,
    S_ACK,
    S_RUN,
    S_FAULT
  } state_t;

  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_ACK_TMO  = 2'd1;
  localparam logic [1:0] FLT_WDOG     = 2'd2;
  localparam logic [1:0] FLT_ACK_LOST = 2'd3;

  localparam int CNT_W     = 16;
  localparam int MAX_STAGE = 8;

  // Index of the lowest cleared bit; 0 when none is cleared.
  function automatic logic [2:0] lowest_zero(input logic [MAX_STAGE-1:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = MAX_STAGE - 1; i >= 0; i--) begin
      if (!v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/car_reset_seq_if.sv
// Subsystem-side signals of the reset sequencer: acks/kick in, resets/status out.
interface car_reset_seq_if #(
  parameter int NSTAGE = 3
) ();

  logic [NSTAGE-1:0] stage_ack;
  logic              wdog_kick;
  logic [NSTAGE-1:0] stage_reset;
  logic              all_ready;
  logic              reset_req;
  logic [1:0]        fault_code;
  logic [2:0]        fault_stage;

  modport master (
    input  stage_ack, wdog_kick,
    output stage_reset, all_ready, reset_req, fault_code, fault_stage
  );

  modport slave (
    output stage_ack, wdog_kick,
    input  stage_reset, all_ready, reset_req, fault_code, fault_stage
  );

endinterface

// File: rtl/car_sat_counter.sv
// 16-bit saturating up-counter with synchronous clear and terminal-count compare.
module car_sat_counter
  import car_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign tc = (count_reg == tc_val);

endmodule

// File: rtl/car_reset_seq.sv
// Releases subsystem resets in order, each gated by its ack; watchdogs the running system
// and raises reset_req on any fault until the generator resets us.
module car_reset_seq
  import car_pkg::*;
#(
  parameter int NSTAGE      = 3,
  parameter int HOLD_CYCLES = 255,
  parameter int ACK_TIMEOUT = 65535,
  parameter int WDOG_CYCLES = 0
) (
  input logic             clk,
  input logic             reset,
  car_reset_seq_if.master bus
);

  localparam logic [2:0]       LAST_IDX = 3'(NSTAGE - 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_TC   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WDOG_TC  = CNT_W'(WDOG_CYCLES - 1);
  localparam bit               WDOG_EN  = (WDOG_CYCLES != 0);

  state_t            state_reg, state_next;
  logic [2:0]        idx_reg, idx_next;
  logic [NSTAGE-1:0] stage_reset_reg, stage_reset_next;
  logic              all_ready_reg, all_ready_next;
  logic              reset_req_reg, reset_req_next;
  logic [1:0]        fault_code_reg, fault_code_next;
  logic [2:0]        fault_stage_reg, fault_stage_next;

  logic [MAX_STAGE-1:0] ack_pad;
  logic                 ack_sel, ack_lost, wdog_exp;
  logic                 seq_tc, seq_en, seq_clr;
  logic                 wdog_tc, wdog_en, wdog_clr;
  logic [CNT_W-1:0]     seq_tc_val;

  // Unused stage slots read as permanently acked so they never fault.
  generate
    for (genvar gi = 0; gi < MAX_STAGE; gi++) begin : g_ack_pad
      if (gi < NSTAGE) begin : g_real
        assign ack_pad[gi] = bus.stage_ack[gi];
      end else begin : g_tie
        assign ack_pad[gi] = 1'b1;
      end
    end
  endgenerate

  assign ack_sel  = ack_pad[idx_reg];
  assign ack_lost = ~&ack_pad;
  assign wdog_exp = WDOG_EN && wdog_tc && !bus.wdog_kick;

  // One timer serves both the hold period and the per-stage ack timeout.
  assign seq_en     = (state_reg == S_HOLD) || (state_reg == S_ACK);
  assign seq_clr    = (state_next != state_reg);
  assign seq_tc_val = (state_reg == S_HOLD) ? HOLD_TC : ACK_TC;

  car_sat_counter u_seq_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (seq_clr),
    .en     (seq_en),
    .tc_val (seq_tc_val),
    .tc     (seq_tc)
  );

  assign wdog_en  = (state_reg == S_RUN);
  assign wdog_clr = (state_reg != S_RUN) || bus.wdog_kick;

  car_sat_counter u_wdog_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (wdog_clr),
    .en     (wdog_en),
    .tc_val (WDOG_TC),
    .tc     (wdog_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_HOLD;
      idx_reg         <= '0;
      stage_reset_reg <= '1;
      all_ready_reg   <= 1'b0;
      reset_req_reg   <= 1'b0;
      fault_code_reg  <= FLT_NONE;
      fault_stage_reg <= '0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      stage_reset_reg <= stage_reset_next;
      all_ready_reg   <= all_ready_next;
      reset_req_reg   <= reset_req_next;
      fault_code_reg  <= fault_code_next;
      fault_stage_reg <= fault_stage_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_HOLD:  if (seq_tc) state_next = S_REL;
      S_REL:   state_next = S_ACK;
      S_ACK: begin
        if (ack_sel) begin
          if (idx_reg == LAST_IDX) begin
            state_next = S_RUN;
          end else begin
            idx_next   = idx_reg + 3'd1;
            state_next = S_REL;
          end
        end else if (seq_tc) begin
          state_next = S_FAULT;
        end
      end
      S_RUN:   if (ack_lost || wdog_exp) state_next = S_FAULT;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_HOLD;
    endcase
  end

  // Outputs are registered alongside the state, so they follow the transition on the same edge.
  always_comb begin
    stage_reset_next = stage_reset_reg;
    all_ready_next   = (state_next == S_RUN);
    reset_req_next   = (state_next == S_FAULT);
    fault_code_next  = fault_code_reg;
    fault_stage_next = fault_stage_reg;
    if (state_reg == S_REL) begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (idx_reg == 3'(i)) stage_reset_next[i] = 1'b0;
      end
    end
    if (state_next == S_FAULT) begin
      stage_reset_next = '1;
      if (state_reg == S_ACK) begin
        fault_code_next  = FLT_ACK_TMO;
        fault_stage_next = idx_reg;
      end else if (state_reg == S_RUN) begin
        if (ack_lost) begin
          fault_code_next  = FLT_ACK_LOST;
          fault_stage_next = lowest_zero(ack_pad);
        end else begin
          fault_code_next  = FLT_WDOG;
          fault_stage_next = '0;
        end
      end
    end
  end

  assign bus.stage_reset = stage_reset_reg;
  assign bus.all_ready   = all_ready_reg;
  assign bus.reset_req   = reset_req_reg;
  assign bus.fault_code  = fault_code_reg;
  assign bus.fault_stage = fault_stage_reg;

endmodule

// File: tb/tb_car_reset_seq.sv
// Bench for car_reset_seq: timeline model checked every cycle plus directed literal checks.
module tb_car_reset_seq;

  localparam int NST  = 3;
  localparam int HOLD = 8;
  localparam int TMO  = 16;
  localparam int WDOG = 32;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  car_reset_seq_if #(.NSTAGE(NST)) bus_a ();
  car_reset_seq_if #(.NSTAGE(NST)) bus_b ();

  car_reset_seq #(
    .NSTAGE(NST), .HOLD_CYCLES(HOLD), .ACK_TIMEOUT(TMO), .WDOG_CYCLES(WDOG)
  ) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  car_reset_seq #(
    .NSTAGE(NST), .HOLD_CYCLES(HOLD), .ACK_TIMEOUT(TMO), .WDOG_CYCLES(0)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  // Timeline model: edges counted since reset release, stage release times, watchdog reference.
  int         m_n   [2];
  int         m_cur [2];
  int         m_rel [2];
  int         m_ref [2];
  logic [2:0] exp_sr    [2];
  logic       exp_ready [2];
  logic       exp_req   [2];
  logic [1:0] exp_code  [2];
  logic [2:0] exp_fst   [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_init(input int d);
    m_n[d]       = 0;
    m_cur[d]     = 0;
    m_rel[d]     = HOLD + 1;
    m_ref[d]     = 0;
    exp_sr[d]    = 3'b111;
    exp_ready[d] = 1'b0;
    exp_req[d]   = 1'b0;
    exp_code[d]  = 2'd0;
    exp_fst[d]   = 3'd0;
  endtask

  task automatic model_fault(input int d, input logic [1:0] code, input int st);
    exp_req[d]   = 1'b1;
    exp_ready[d] = 1'b0;
    exp_sr[d]    = 3'b111;
    exp_code[d]  = code;
    exp_fst[d]   = 3'(st);
  endtask

  task automatic model_step(input int d, input logic [2:0] ack, input logic kick, input int wdog);
    int low;
    m_n[d]++;
    if (!exp_req[d]) begin
      if (!exp_ready[d]) begin
        if (m_n[d] == m_rel[d]) begin
          exp_sr[d][m_cur[d]] = 1'b0;
        end else if (m_n[d] > m_rel[d]) begin
          if (ack[m_cur[d]]) begin
            if (m_cur[d] == NST - 1) begin
              exp_ready[d] = 1'b1;
              m_ref[d]     = m_n[d];
            end else begin
              m_cur[d]++;
              m_rel[d] = m_n[d] + 1;
            end
          end else if (m_n[d] - m_rel[d] == TMO) begin
            model_fault(d, 2'd1, m_cur[d]);
          end
        end
      end else begin
        if (ack != 3'b111) begin
          low = 0;
          for (int i = NST - 1; i >= 0; i--) if (!ack[i]) low = i;
          model_fault(d, 2'd3, low);
        end else if (kick) begin
          m_ref[d] = m_n[d];
        end else if (wdog != 0 && m_n[d] - m_ref[d] == wdog) begin
          model_fault(d, 2'd2, 0);
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) model_init(0);
    else       model_step(0, bus_a.stage_ack, bus_a.wdog_kick, WDOG);
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) model_init(1);
    else       model_step(1, bus_b.stage_ack, bus_b.wdog_kick, 0);
  end

  always @(negedge clk) begin
    check("a_outputs",
          32'({bus_a.stage_reset, bus_a.all_ready, bus_a.reset_req, bus_a.fault_code, bus_a.fault_stage}),
          32'({exp_sr[0], exp_ready[0], exp_req[0], exp_code[0], exp_fst[0]}));
    check("b_outputs",
          32'({bus_b.stage_reset, bus_b.all_ready, bus_b.reset_req, bus_b.fault_code, bus_b.fault_stage}),
          32'({exp_sr[1], exp_ready[1], exp_req[1], exp_code[1], exp_fst[1]}));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_a(input logic [2:0] ack);
    rst_a = 1'b1;
    bus_a.stage_ack = ack;
    bus_a.wdog_kick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    bus_a.stage_ack = 3'b000;
    bus_a.wdog_kick = 1'b0;
    bus_b.stage_ack = 3'b111;
    bus_b.wdog_kick = 1'b0;
    @(negedge clk);
    check("reset_sr", 32'(bus_a.stage_reset), 32'h7);
    check("reset_req", 32'(bus_a.reset_req), 32'h0);

    // 1: nominal, each ack raised a few cycles after its release
    reset_a(3'b000);
    step(8);  check("s1_sr_e8", 32'(bus_a.stage_reset), 32'h7);
    step(1);  check("s1_sr_e9", 32'(bus_a.stage_reset), 32'h6);
    step(2);  bus_a.stage_ack = 3'b001;
    step(1);  check("s1_sr_e12", 32'(bus_a.stage_reset), 32'h6);
    step(1);  check("s1_sr_e13", 32'(bus_a.stage_reset), 32'h4);
    step(2);  bus_a.stage_ack = 3'b011;
    step(2);  check("s1_sr_e17", 32'(bus_a.stage_reset), 32'h0);
              check("s1_rdy_e17", 32'(bus_a.all_ready), 32'h0);
    step(2);  bus_a.stage_ack = 3'b111;
    step(1);  check("s1_rdy_e20", 32'(bus_a.all_ready), 32'h1);
              check("s1_req_e20", 32'(bus_a.reset_req), 32'h0);
    $display("[TB] scenario 1: nominal sequence reached run");

    // 2: ack[1] never rises
    reset_a(3'b001);
    step(26); check("s2_req_e26", 32'(bus_a.reset_req), 32'h0);
    step(1);  check("s2_req_e27", 32'(bus_a.reset_req), 32'h1);
              check("s2_code", 32'(bus_a.fault_code), 32'h1);
              check("s2_stage", 32'(bus_a.fault_stage), 32'h1);
              check("s2_sr", 32'(bus_a.stage_reset), 32'h7);
    step(5);  check("s2_code_frozen", 32'(bus_a.fault_code), 32'h1);
    $display("[TB] scenario 2: ack timeout on stage 1");

    // 3: watchdog kicked every 20 cycles, then left to expire
    reset_a(3'b111);
    step(14); check("s3_rdy_e14", 32'(bus_a.all_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step(19); bus_a.wdog_kick = 1'b1;
      step(1);  bus_a.wdog_kick = 1'b0;
      check("s3_kicked_code", 32'(bus_a.fault_code), 32'h0);
    end
    step(31); check("s3_code_k31", 32'(bus_a.fault_code), 32'h0);
              check("s3_rdy_k31", 32'(bus_a.all_ready), 32'h1);
    step(1);  check("s3_code_k32", 32'(bus_a.fault_code), 32'h2);
              check("s3_stage_k32", 32'(bus_a.fault_stage), 32'h0);
              check("s3_req_k32", 32'(bus_a.reset_req), 32'h1);
    $display("[TB] scenario 3: watchdog expiry");

    // 4: two acks lost in the same cycle
    reset_a(3'b111);
    step(14); check("s4_rdy", 32'(bus_a.all_ready), 32'h1);
    step(5);  bus_a.stage_ack = 3'b010;
    step(1);  check("s4_code", 32'(bus_a.fault_code), 32'h3);
              check("s4_stage", 32'(bus_a.fault_stage), 32'h0);
              check("s4_rdy_off", 32'(bus_a.all_ready), 32'h0);
    $display("[TB] scenario 4: ack lost in run");

    // 5: asynchronous reset while waiting on stage 1
    reset_a(3'b001);
    step(11); check("s5_sr_e11", 32'(bus_a.stage_reset), 32'h4);
    step(3);
    #2 rst_a = 1'b1;
    #1 check("s5_async_sr", 32'(bus_a.stage_reset), 32'h7);
       check("s5_async_misc", 32'({bus_a.all_ready, bus_a.reset_req, bus_a.fault_code, bus_a.fault_stage}), 32'h0);
    reset_a(3'b001);
    step(8);  check("s5_sr_e8", 32'(bus_a.stage_reset), 32'h7);
    step(1);  check("s5_sr_e9", 32'(bus_a.stage_reset), 32'h6);
    $display("[TB] scenario 5: reset mid-sequence restarts hold");

    // 6: acks tied high, watchdog disabled
    @(negedge clk);
    rst_b = 1'b0;
    step(9);  check("s6_sr_e9", 32'(bus_b.stage_reset), 32'h6);
    step(1);  check("s6_sr_e10", 32'(bus_b.stage_reset), 32'h6);
    step(1);  check("s6_sr_e11", 32'(bus_b.stage_reset), 32'h4);
    step(2);  check("s6_sr_e13", 32'(bus_b.stage_reset), 32'h0);
              check("s6_rdy_e13", 32'(bus_b.all_ready), 32'h0);
    step(1);  check("s6_rdy_e14", 32'(bus_b.all_ready), 32'h1);
    step(3000);
    check("s6_rdy_long", 32'(bus_b.all_ready), 32'h1);
    check("s6_code_long", 32'(bus_b.fault_code), 32'h0);
    check("s6_req_long", 32'(bus_b.reset_req), 32'h0);
    $display("[TB] scenario 6: pre-asserted acks, no watchdog");

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
